// File: rtl/coef_ram_mp.sv
// Dual-write/dual-read coefficient RAM with lane masks, write-first registered reads and a zero-fill sweep.
// Define COEF_RAM_OOR_ERR_EN to add the sticky out-of-range error output oor_err.
module coef_ram_mp #(
    parameter int LANE_W = 12,
    parameter int LANES  = 8,
    parameter int AW     = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_start,
    output logic                      busy,
    output logic                      clr_done,
`ifdef COEF_RAM_OOR_ERR_EN
    output logic                      oor_err,
`endif
    input  logic                      wena,
    input  logic                      wenb,
    input  logic [LANES-1:0]          wmaska,
    input  logic [LANES-1:0]          wmaskb,
    input  logic [AW-1:0]             waddra,
    input  logic [AW-1:0]             waddrb,
    input  logic [LANE_W*LANES-1:0]   dina,
    input  logic [LANE_W*LANES-1:0]   dinb,
    input  logic                      rena,
    input  logic                      renb,
    input  logic [AW-1:0]             raddra,
    input  logic [AW-1:0]             raddrb,
    output logic [LANE_W*LANES-1:0]   douta,
    output logic [LANE_W*LANES-1:0]   doutb,
    output logic                      valida,
    output logic                      validb
);

    localparam int DW = LANE_W * LANES;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state;
    logic [AW:0]   ptr;
    logic [AW:0]   ptr1;
    logic [AW:0]   ptr2;
    logic [DW-1:0] mem [DEPTH];

    logic idle;
    logic wacc_a;
    logic wacc_b;
    logic racc_a;
    logic racc_b;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    assign idle     = (state == ST_IDLE);
    assign busy     = (state == ST_CLEAR);
    assign clr_done = (state == ST_DONE);

    assign wacc_a = idle && wena && in_range(waddra);
    assign wacc_b = idle && wenb && in_range(waddrb);
    assign racc_a = !busy && rena;
    assign racc_b = !busy && renb;

    assign ptr1 = ptr + (AW+1)'(1);
    assign ptr2 = ptr + (AW+1)'(2);

    // Word as it will look after this cycle's writes: A lanes first, B lanes override.
    function automatic logic [DW-1:0] post_write(input logic [AW-1:0] addr);
        logic [DW-1:0] w;
        w = '0;
        if (in_range(addr)) begin
            w = mem[addr];
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wacc_a && (waddra == addr) && wmaska[i])
                    w[i*LANE_W +: LANE_W] = dina[i*LANE_W +: LANE_W];
                if (wacc_b && (waddrb == addr) && wmaskb[i])
                    w[i*LANE_W +: LANE_W] = dinb[i*LANE_W +: LANE_W];
            end
        end
        return w;
    endfunction

    // Array storage; B's non-blocking lane writes land after A's, so B wins on overlap.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr[AW-1:0]] <= '0;
            if (ptr1 < DEPTH_W)
                mem[ptr1[AW-1:0]] <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wacc_a && wmaska[i])
                    mem[waddra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
                if (wacc_b && wmaskb[i])
                    mem[waddrb][i*LANE_W +: LANE_W] <= dinb[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_CLEAR;
            ptr    <= '0;
            douta  <= '0;
            doutb  <= '0;
            valida <= 1'b0;
            validb <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    ptr <= ptr2;
                    if (ptr2 >= DEPTH_W)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            valida <= racc_a;
            validb <= racc_b;
            if (racc_a)
                douta <= post_write(raddra);
            if (racc_b)
                doutb <= post_write(raddrb);
        end
    end

`ifdef COEF_RAM_OOR_ERR_EN
    logic oor_hit;

    assign oor_hit = (idle && wena && !in_range(waddra)) ||
                     (idle && wenb && !in_range(waddrb)) ||
                     (racc_a && !in_range(raddra)) ||
                     (racc_b && !in_range(raddrb));

    // An accepted clear takes precedence over a same-cycle out-of-range hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            oor_err <= 1'b0;
        else if (idle && clr_start)
            oor_err <= 1'b0;
        else if (oor_hit)
            oor_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_coef_ram_mp.sv
// Randomised bench for coef_ram_mp: drives a power-of-two and a non-power-of-two instance from one stimulus
// stream and checks both against an array model of the word store.
module tb_coef_ram_mp;

    localparam int LW   = 12;
    localparam int NL   = 8;
    localparam int AW   = 10;
    localparam int DW   = LW * NL;
    localparam int DEP0 = 1024;
    localparam int DEP1 = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr_start, wena, wenb, rena, renb;
    logic [NL-1:0] wmaska, wmaskb;
    logic [AW-1:0] waddra, waddrb, raddra, raddrb;
    logic [DW-1:0] dina, dinb;

    logic          busy_w [2];
    logic          done_w [2];
    logic          va_w   [2];
    logic          vb_w   [2];
    logic [DW-1:0] da_w   [2];
    logic [DW-1:0] db_w   [2];
`ifdef COEF_RAM_OOR_ERR_EN
    logic          oor_w  [2];
`endif

    coef_ram_mp #(.LANE_W(LW), .LANES(NL), .AW(AW), .DEPTH(DEP0)) u0 (
        .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy_w[0]), .clr_done(done_w[0]),
`ifdef COEF_RAM_OOR_ERR_EN
        .oor_err(oor_w[0]),
`endif
        .wena(wena), .wenb(wenb), .wmaska(wmaska), .wmaskb(wmaskb),
        .waddra(waddra), .waddrb(waddrb), .dina(dina), .dinb(dinb),
        .rena(rena), .renb(renb), .raddra(raddra), .raddrb(raddrb),
        .douta(da_w[0]), .doutb(db_w[0]), .valida(va_w[0]), .validb(vb_w[0])
    );

    coef_ram_mp #(.LANE_W(LW), .LANES(NL), .AW(AW), .DEPTH(DEP1)) u1 (
        .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy_w[1]), .clr_done(done_w[1]),
`ifdef COEF_RAM_OOR_ERR_EN
        .oor_err(oor_w[1]),
`endif
        .wena(wena), .wenb(wenb), .wmaska(wmaska), .wmaskb(wmaskb),
        .waddra(waddra), .waddrb(waddrb), .dina(dina), .dinb(dinb),
        .rena(rena), .renb(renb), .raddra(raddra), .raddrb(raddrb),
        .douta(da_w[1]), .doutb(db_w[1]), .valida(va_w[1]), .validb(vb_w[1])
    );

    logic [DW-1:0] mdl    [2][1024];
    int            depth  [2] = '{DEP0, DEP1};
    logic [DW-1:0] hold_a [2];
    logic [DW-1:0] hold_b [2];
    bit            oor_m  [2];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        clr_start = 1'b0;
        wena = 1'b0; wenb = 1'b0; rena = 1'b0; renb = 1'b0;
        wmaska = '0; wmaskb = '0;
        waddra = '0; waddrb = '0; raddra = '0; raddrb = '0;
        dina = '0; dinb = '0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 1024; a++)
                mdl[k][a] = '0;
    endtask

    // One clock with the current inputs; in idle mode the model applies both writes before reading.
    task automatic step(input bit busy_mode);
        bit va, vb;
        for (int k = 0; k < 2; k++) begin
            if (!busy_mode) begin
                if (clr_start)
                    oor_m[k] = 1'b0;
                else if ((wena && waddra >= depth[k]) || (wenb && waddrb >= depth[k]) ||
                         (rena && raddra >= depth[k]) || (renb && raddrb >= depth[k]))
                    oor_m[k] = 1'b1;
                for (int i = 0; i < NL; i++) begin
                    if (wena && wmaska[i] && waddra < depth[k])
                        mdl[k][waddra][i*LW +: LW] = dina[i*LW +: LW];
                    if (wenb && wmaskb[i] && waddrb < depth[k])
                        mdl[k][waddrb][i*LW +: LW] = dinb[i*LW +: LW];
                end
                if (rena) hold_a[k] = (raddra < depth[k]) ? mdl[k][raddra] : '0;
                if (renb) hold_b[k] = (raddrb < depth[k]) ? mdl[k][raddrb] : '0;
            end
        end
        va = !busy_mode && rena;
        vb = !busy_mode && renb;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valida%0d", k), va_w[k], va);
            chk($sformatf("validb%0d", k), vb_w[k], vb);
            chk($sformatf("douta%0d", k), da_w[k], hold_a[k]);
            chk($sformatf("doutb%0d", k), db_w[k], hold_b[k]);
            if (busy_mode) chk($sformatf("busy%0d", k), busy_w[k], 1'b1);
`ifdef COEF_RAM_OOR_ERR_EN
            chk($sformatf("oor%0d", k), oor_w[k], oor_m[k]);
`endif
        end
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_douta%0d", k), da_w[k], '0);
            chk($sformatf("rst_doutb%0d", k), db_w[k], '0);
            chk($sformatf("rst_valida%0d", k), va_w[k], 1'b0);
            chk($sformatf("rst_validb%0d", k), vb_w[k], 1'b0);
            chk($sformatf("rst_done%0d", k), done_w[k], 1'b0);
            chk($sformatf("rst_busy%0d", k), busy_w[k], 1'b1);
`ifdef COEF_RAM_OOR_ERR_EN
            chk($sformatf("rst_oor%0d", k), oor_w[k], 1'b0);
`endif
        end
    endtask

    // Called right after rst falls; a clear request at cycle pulse_at must be ignored mid-sweep.
    task automatic wait_sweep(input int pulse_at);
        int done_at  [2];
        int pulses   [2];
        int busy_cnt [2];
        int exp_len  [2];
        exp_len = '{DEP0 / 2, DEP1 / 2};
        for (int k = 0; k < 2; k++) begin
            done_at[k] = -1; pulses[k] = 0; busy_cnt[k] = 0;
        end
        for (int n = 0; n < 530; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (done_at[k] < 0 && busy_w[k]) busy_cnt[k]++;
                if (done_w[k]) begin
                    pulses[k]++;
                    if (done_at[k] < 0) done_at[k] = n;
                    chk($sformatf("done_busy%0d", k), busy_w[k], 1'b0);
                end
            end
            clr_start = (n == pulse_at);
            @(posedge clk);
            #1;
        end
        clr_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sweep_len%0d", k), done_at[k], exp_len[k]);
            chk($sformatf("busy_cycles%0d", k), busy_cnt[k], exp_len[k]);
            chk($sformatf("done_pulses%0d", k), pulses[k], 1);
            chk($sformatf("idle_busy%0d", k), busy_w[k], 1'b0);
        end
        clear_model();
    endtask

    task automatic read_all();
        for (int a = 0; a < 1024; a++) begin
            rena = 1'b1; raddra = AW'(a);
            renb = 1'b1; raddrb = AW'(1023 - a);
            step(1'b0);
        end
        idle_inputs();
    endtask

    function automatic logic [AW-1:0] pick();
        case ($urandom_range(0, 2))
            0:       return AW'($urandom_range(0, 15));
            1:       return AW'($urandom_range(990, 1023));
            default: return AW'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic rand_ops(input int n);
        for (int c = 0; c < n; c++) begin
            wena   = ($urandom_range(0, 1) == 1);
            wenb   = ($urandom_range(0, 1) == 1);
            rena   = ($urandom_range(0, 2) != 0);
            renb   = ($urandom_range(0, 2) != 0);
            wmaska = NL'($urandom);
            wmaskb = NL'($urandom);
            dina   = {$urandom, $urandom, $urandom};
            dinb   = {$urandom, $urandom, $urandom};
            waddra = pick();
            waddrb = ($urandom_range(0, 3) == 0) ? waddra : pick();
            raddra = ($urandom_range(0, 3) == 0) ? waddra : pick();
            raddrb = ($urandom_range(0, 3) == 0) ? waddrb : pick();
            step(1'b0);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        clear_model();
        for (int k = 0; k < 2; k++) begin
            hold_a[k] = '0; hold_b[k] = '0; oor_m[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        wait_sweep(-1);
        read_all();

        // Masked write: full word of ones, then zeros into lanes 3..0 only.
        wena = 1'b1; waddra = 10'd5; dina = '1; wmaska = 8'hFF;
        step(1'b0);
        dina = '0; wmaska = 8'h0F;
        step(1'b0);
        idle_inputs();
        rena = 1'b1; raddra = 10'd5;
        step(1'b0);
        chk("mask_word", da_w[0], {{4{12'hFFF}}, {4{12'h000}}});
        chk("mask_valid", va_w[0], 1'b1);

        // Same-address collision, B owns lanes 7..4.
        idle_inputs();
        wena = 1'b1; waddra = 10'd7; dina = {8{12'h001}}; wmaska = 8'hFF;
        wenb = 1'b1; waddrb = 10'd7; dinb = {8{12'h002}}; wmaskb = 8'hF0;
        step(1'b0);
        idle_inputs();
        rena = 1'b1; raddra = 10'd7;
        step(1'b0);
        chk("collide_word", da_w[1], {{4{12'h002}}, {4{12'h001}}});

        // Read-during-write on port B returns the freshly written lane.
        idle_inputs();
        wena = 1'b1; waddra = 10'd9; dina = 96'hABC; wmaska = 8'h01;
        renb = 1'b1; raddrb = 10'd9;
        step(1'b0);
        chk("fwd_word", db_w[0], 96'hABC);
        chk("fwd_valid", vb_w[0], 1'b1);

        // Address 1010 is in range for u0 only.
        idle_inputs();
        wenb = 1'b1; waddrb = 10'd1010; dinb = '1; wmaskb = 8'hFF;
        step(1'b0);
        idle_inputs();
        rena = 1'b1; raddra = 10'd1010;
        step(1'b0);
        chk("oor_rd_u0", da_w[0], '1);
        chk("oor_rd_u1", da_w[1], '0);
        chk("oor_valid_u1", va_w[1], 1'b1);
        idle_inputs();

        rand_ops(3000);

        // Retriggered sweep with blocked traffic, then a reset partway through.
        clr_start = 1'b1;
        step(1'b0);
        clr_start = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("busy_rise%0d", k), busy_w[k], 1'b1);
        for (int c = 1; c <= 200; c++) begin
            if (c == 100) begin
                wena = 1'b1; waddra = 10'd3; dina = '1; wmaska = 8'hFF;
                rena = 1'b1; raddra = 10'd3;
                renb = 1'b1; raddrb = 10'd3;
            end
            step(1'b1);
            idle_inputs();
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            hold_a[k] = '0; hold_b[k] = '0; oor_m[k] = 1'b0;
        end
        #1;
        chk_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        wait_sweep(10);
        read_all();
        rand_ops(500);
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coef_ram_mp.md
Name: coef_ram_mp

Overview:
- Parametrised dual-write/dual-read coefficient RAM for the polynomial datapath; successor to the fixed 96x1024 dual-port store.
- Adds per-lane write masks, registered reads with write-forwarding, deterministic collision priority and a sequential clear engine.
- The clear engine replaces the single-cycle array reset, auto-runs after reset and can be retriggered between NTT/sampling passes.
- Sits between the NTT/PWM units and the polynomial controller.

Parameters:
- LANE_W, 12, bits per coefficient lane.
- LANES, 8, lanes per word; DW = LANE_W*LANES (default 96).
- AW, 10, address width.
- DEPTH, 1024, number of words; DEPTH <= 2^AW, may be non-power-of-2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clr_start  in  1  pulse: start zero-fill sweep
- busy  out  1  clear engine running
- clr_done  out  1  one-cycle pulse at end of sweep
- wena, wenb  in  1  write enables, ports A/B
- wmaska, wmaskb  in  LANES  per-lane write masks (1 = write lane)
- waddra, waddrb  in  AW  write addresses
- dina, dinb  in  DW  write data
- rena, renb  in  1  read enables
- raddra, raddrb  in  AW  read addresses
- douta, doutb  out  DW  registered read data
- valida, validb  out  1  read data valid, one cycle after the accepted read

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high on rst.
- Reset values: douta = doutb = 0, valida = validb = 0, clr_done = 0, busy = 1, clear pointer = 0. The array itself is not reset asynchronously.
- Clear start: the engine begins sweeping on the first clk edge after rst deasserts.
- States: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start; busy rises the next cycle.
  - CLEAR writes zero to words ptr and ptr+1 each cycle (ptr+1 is skipped if >= DEPTH); ptr += 2.
  - CLEAR -> DONE after the cycle that writes word DEPTH-1, i.e. ceil(DEPTH/2) cycles.
  - DONE lasts one cycle: clr_done = 1 and busy = 0 in that cycle, then -> IDLE.
- rst asserted mid-sweep: pointer returns to 0 and the sweep restarts after deassertion.
- clr_start during CLEAR or DONE is ignored.
- While busy = 1:
  - External writes are dropped.
  - Reads are not accepted: valid stays 0 and dout holds its value.
- Write, IDLE only:
  - On the clk edge, each lane i with wen = 1 and wmask[i] = 1 is updated; other lanes keep their contents.
  - wmask = 0 is a no-op.
- Collision: A and B write the same address in the same cycle -> per lane, B wins where both masks are set; lanes set in only one mask take that port's data.
- Read:
  - rena/renb sampled at the clk edge; dout and valid update at that edge (latency 1).
  - valid = 0 in a cycle with no read, and dout holds its last value.
- Read-during-write to the same address: write-first. dout returns the post-write word, including lane merge and B-over-A priority.
- Out of range (address >= DEPTH): writes dropped; reads return 0 with valid = 1.
- Both read ports may read any address independently, including the same address.

Optional Feature:
- Macro: COEF_RAM_OOR_ERR_EN.
- Defined: adds output oor_err (1 bit, reset 0).
  - Sticky-set on any accepted write or read with address >= DEPTH.
  - Cleared only by rst or by clr_start being accepted.
- Undefined: no port; out-of-range accesses are silently handled as above.

Test Plan:
- Post-reset sweep (defaults): rst high 3 cycles, then low -> busy = 1 for 512 cycles, clr_done pulses once on cycle 512, busy = 0 that cycle; read all 1024 addresses -> all 0.
- Masked write: write 0x...FFF (all ones) to addr 5 with wmaska = 8'hFF, then dina = 0 with wmaska = 8'h0F, then read addr 5 -> douta = upper 4 lanes 0xFFF, lower 4 lanes 0x000, valida = 1 one cycle after the read.
- Collision: same cycle, A writes addr 7 data = 1 per lane with mask 0xFF; B writes addr 7 data = 2 per lane with mask 0xF0 -> read gives lanes 7..4 = 2, lanes 3..0 = 1.
- Forwarding: write addr 9 = 0xABC in lane 0 while raddrb = 9, renb = 1 in the same cycle -> next cycle doutb lane 0 = 0xABC.
- Busy blocking plus mid-sweep reset: clr_start, then at sweep cycle 100 issue a write and a read -> write lost, valida stays 0. Assert rst at cycle 200 -> sweep restarts, taking 512 more cycles to reach clr_done.
- DEPTH = 1000, COEF_RAM_OOR_ERR_EN defined: write addr 1010 -> no array change, oor_err = 1; read addr 1010 -> dout = 0, valid = 1; clr_start -> oor_err = 0, sweep takes 500 cycles.
